unidad_load_store: RTL and testbench
====================================

// Module: unidad_load_store
// PURPOSE
//  Load/store formatting stage between the EX/MEM pipeline register and the word-wide data memory.
//  Turns byte/halfword/word load and store requests into word accesses:
//   - loads: extracts the lane and sign- or zero-extends it.
//   - sub-word stores: read-modify-write (RMW) over whole words.
//  Holds the pipeline through o_Stall while busy.
//  Keeps saturating load/store counters for the debug unit.
// PARAMETERS
//  NBITS     32  data/address width (byte addresses on the pipeline side)
//  CNT_BITS  16  width of debug access counters
// PORTS
//  i_clk         in   1         clock; all state updates on posedge
//  i_reset       in   1         synchronous, active-high reset
//  i_Valid       in   1         request present (accepted when i_Valid & o_Ready at posedge)
//  o_Ready       out  1         high only in IDLE
//  i_Store       in   1         1 = store, 0 = load
//  i_Op          in   3         000 B, 001 H, 011 W, 100 BU, 101 HU (load only)
//  i_Addr        in   NBITS     byte address from ALU
//  i_WData       in   NBITS     store data from register file (lanes taken from LSBs)
//  o_Done        out  1         one-cycle pulse: request finished
//  o_Error       out  1         valid with o_Done: misaligned or illegal op, no memory access made
//  o_LoadData    out  NBITS     extended load result, valid with o_Done on loads, else held
//  o_Stall       out  1         high whenever state != IDLE
//  o_MemAddr     out  NBITS     word index = i_Addr >> 2 (captured)
//  o_MemRead     out  1         memory read enable
//  o_MemWrite    out  1         memory write enable (memory writes on negedge)
//  o_MemWData    out  NBITS     word to write
//  i_MemRData    in   NBITS     memory read data (combinational from o_MemAddr)
//  o_LoadCount   out  CNT_BITS  completed good loads, saturating
//  o_StoreCount  out  CNT_BITS  completed good stores, saturating
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, except o_Ready = 1; counters 0.
//  Byte lanes are little-endian: lane k = bits [8k+7:8k], with k = addr[1:0].
//  Accept: captures op, addr and data.
//   - Illegal op (010, 110, 111; store with i_Op[2]=1) -> RESP with error.
//   - Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0) -> RESP with error.
//  FSM states: IDLE, RD, WR, RESP. All memory outputs are registered per state.
//   - IDLE -> RD: loads and SB/SH.
//   - IDLE -> WR: SW.
//   - RD: o_MemRead=1. At the end of RD, i_MemRData is captured. Then:
//     - load: extract lane into o_LoadData -> RESP.
//     - SB/SH: merge i_WData lane(s) into the read word -> WR.
//   - WR: o_MemWrite=1 and o_MemWData = merged word (SW: i_WData unchanged) -> RESP.
//   - RESP: o_Done=1 for one cycle, then -> IDLE.
//  Latencies (accept edge = T; o_Done is high in the cycle named):
//   - load: T+2
//   - SW: T+2
//   - SB/SH: T+3
//   - error: T+1
//  Sign extension:
//   - B/H replicate bit 7/15 of the lane.
//   - BU/HU zero-fill.
//   - W passes through.
//  o_LoadData is not updated by stores or errors.
//  o_MemRead and o_MemWrite are never high together. Both are 0 in IDLE and RESP.
//  i_Valid while busy is ignored (o_Ready=0). There is no queueing.
//  Counters increment in RESP, non-error only, and stick at all-ones.
//  Reset mid-operation: the same edge returns to IDLE and drops MemRead/MemWrite. No o_Done. The RMW is abandoned.
//   - If reset lands in WR, the memory negedge write of that cycle has already occurred.
//  o_MemAddr holds its last value in IDLE.
// TESTING
//  1. mem[1]=32'h8899AABB; LB addr 5
//     -> RD with o_MemAddr=1; o_Done at T+2; o_LoadData=32'hFFFFFFAA; LoadCount=1.
//  2. Same word; LHU addr 6
//     -> o_LoadData=32'h00008899.
//  3. mem[2]=32'h11223344; SB addr 9, i_WData=32'h000000EE
//     -> RD, then WR with o_MemWData=32'h1122EE44; o_Done at T+3; StoreCount=1.
//  4. LW addr 6 -> o_Done+o_Error at T+1, no MemRead/MemWrite, counters unchanged.
//     i_Store=1, i_Op=100 -> same response.
//  5. SH addr 2 with reset asserted in the RD cycle
//     -> next cycle IDLE, o_Ready=1, o_Done never pulses, memory word unchanged.
//  6. i_Valid held high for back-to-back loads
//     -> second accepted only after RESP (o_Ready=1 in IDLE).
//     Force LoadCount to all-ones -> one more load leaves it at all-ones.

Source files
------------

// File: rtl/unidad_load_store.sv
// unidad_load_store: byte/half/word load-store formatter with read-modify-write stores,
// pipeline stall while busy and saturating debug access counters.
module unidad_load_store #(
    parameter int NBITS    = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_Valid,
    output logic                o_Ready,
    input  logic                i_Store,
    input  logic [2:0]          i_Op,
    input  logic [NBITS-1:0]    i_Addr,
    input  logic [NBITS-1:0]    i_WData,
    output logic                o_Done,
    output logic                o_Error,
    output logic [NBITS-1:0]    o_LoadData,
    output logic                o_Stall,
    output logic [NBITS-1:0]    o_MemAddr,
    output logic                o_MemRead,
    output logic                o_MemWrite,
    output logic [NBITS-1:0]    o_MemWData,
    input  logic [NBITS-1:0]    i_MemRData,
    output logic [CNT_BITS-1:0] o_LoadCount,
    output logic [CNT_BITS-1:0] o_StoreCount
);
    localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3;

    logic [1:0]       state;
    logic [2:0]       op;
    logic [1:0]       off;
    logic             store;
    logic             err;
    logic [NBITS-1:0] wdata;
    logic             illegal, misaligned;
    logic [NBITS-1:0] lane, ext, mask, merged;

    always_comb begin
        illegal    = i_Op == 3'b010 || i_Op[2:1] == 2'b11 || (i_Store && i_Op[2]);
        misaligned = (i_Op[1:0] == 2'b01 && i_Addr[0]) || (i_Op == 3'b011 && i_Addr[1:0] != 2'b00);
        lane       = i_MemRData >> {off, 3'b000};
        ext        = op == 3'b000 ? {{(NBITS-8){lane[7]}}, lane[7:0]} :
                     op == 3'b001 ? {{(NBITS-16){lane[15]}}, lane[15:0]} :
                     op == 3'b100 ? {{(NBITS-8){1'b0}}, lane[7:0]} :
                     op == 3'b101 ? {{(NBITS-16){1'b0}}, lane[15:0]} : i_MemRData;
        // Halfword stores are already known aligned, so a 16-bit mask never wraps.
        mask       = (op[0] ? NBITS'(16'hFFFF) : NBITS'(8'hFF)) << {off, 3'b000};
        merged     = (i_MemRData & ~mask) | ((wdata << {off, 3'b000}) & mask);
    end

    assign o_Ready = state == IDLE;
    assign o_Stall = state != IDLE;
    assign o_Done  = state == RESP;
    assign o_Error = o_Done && err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            op           <= '0;
            off          <= '0;
            store        <= 1'b0;
            err          <= 1'b0;
            wdata        <= '0;
            o_LoadData   <= '0;
            o_MemAddr    <= '0;
            o_MemRead    <= 1'b0;
            o_MemWrite   <= 1'b0;
            o_MemWData   <= '0;
            o_LoadCount  <= '0;
            o_StoreCount <= '0;
        end else begin
            case (state)
                IDLE: if (i_Valid) begin
                    op        <= i_Op;
                    off       <= i_Addr[1:0];
                    store     <= i_Store;
                    wdata     <= i_WData;
                    err       <= illegal || misaligned;
                    o_MemAddr <= i_Addr >> 2;
                    if (illegal || misaligned) begin
                        state <= RESP;
                    end else if (i_Store && i_Op == 3'b011) begin
                        state      <= WR;
                        o_MemWrite <= 1'b1;
                        o_MemWData <= i_WData;
                    end else begin
                        state     <= RD;
                        o_MemRead <= 1'b1;
                    end
                end
                RD: begin
                    o_MemRead <= 1'b0;
                    if (store) begin
                        o_MemWData <= merged;
                        o_MemWrite <= 1'b1;
                        state      <= WR;
                    end else begin
                        o_LoadData <= ext;
                        state      <= RESP;
                    end
                end
                WR: begin
                    o_MemWrite <= 1'b0;
                    state      <= RESP;
                end
                default: begin
                    state <= IDLE;
                    if (!err && !store && !(&o_LoadCount)) o_LoadCount <= o_LoadCount + CNT_BITS'(1);
                    if (!err && store && !(&o_StoreCount)) o_StoreCount <= o_StoreCount + CNT_BITS'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_unidad_load_store.sv
// tb_unidad_load_store: directed vector table, reset/back-to-back sequences and random
// traffic compared against a byte-array reference model of the load/store unit.
module tb_unidad_load_store;
    localparam int CB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0, store = 1'b0;
    logic [2:0]    op = '0;
    logic [31:0]   addr = '0, wdata = '0;
    logic          ready, done, error, stall, mem_read, mem_write;
    logic [31:0]   load_data, mem_addr, mem_wdata, mem_rdata;
    logic [CB-1:0] load_count, store_count;

    logic [31:0] mem [16];
    logic [7:0]  rb [64];
    int          ref_loads, ref_stores;
    logic [31:0] last_load;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    unidad_load_store #(.NBITS(32), .CNT_BITS(CB)) dut (
        .i_clk(clk), .i_reset(rst), .i_Valid(valid), .o_Ready(ready), .i_Store(store),
        .i_Op(op), .i_Addr(addr), .i_WData(wdata), .o_Done(done), .o_Error(error),
        .o_LoadData(load_data), .o_Stall(stall), .o_MemAddr(mem_addr), .o_MemRead(mem_read),
        .o_MemWrite(mem_write), .o_MemWData(mem_wdata), .i_MemRData(mem_rdata),
        .o_LoadCount(load_count), .o_StoreCount(store_count)
    );

    assign mem_rdata = mem[mem_addr[3:0]];
    always @(negedge clk) if (mem_write) mem[mem_addr[3:0]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int size_of(input logic [2:0] o);
        return o == 3'b011 ? 4 : (o == 3'b001 || o == 3'b101) ? 2 : 1;
    endfunction

    function automatic logic ref_err(input logic st, input logic [2:0] o, input logic [31:0] a);
        logic legal;
        legal = (o == 3'b000 || o == 3'b001 || o == 3'b011 || o == 3'b100 || o == 3'b101) && !(st && o >= 3'b100);
        return !(legal && (a % size_of(o)) == 0);
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = rb[a[5:0]];
        h = {rb[a[5:0] + 6'd1], rb[a[5:0]]};
        case (o)
            3'b000:  return 32'($signed(b));
            3'b100:  return 32'(b);
            3'b001:  return 32'($signed(h));
            3'b101:  return 32'(h);
            default: return ref_word(int'(a[5:2]));
        endcase
    endfunction

    function automatic int sat(input int v);
        return v >= (1 << CB) - 1 ? (1 << CB) - 1 : v + 1;
    endfunction

    // Drives one request from IDLE and waits (bounded) for its o_Done pulse.
    task automatic run(input logic st, input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic e, output logic both);
        valid = 1'b1; store = st; op = o; addr = a; wdata = wd;
        @(posedge clk); #1;
        valid = 1'b0;
        lat = 0; e = 1'b0; both = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_read && mem_write) both = 1'b1;
            if (done) begin lat = c; e = error; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    // Applies a request to the model, then compares every observable against it.
    task automatic txn(input string tag, input logic st, input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd);
        int   lat, exp_lat;
        logic e, both, exp_e;
        run(st, o, a, wd, lat, e, both);
        exp_e   = ref_err(st, o, a);
        exp_lat = exp_e ? 1 : (st && size_of(o) < 4) ? 3 : 2;
        if (!exp_e && st) begin
            for (int i = 0; i < size_of(o); i++) rb[a[5:0] + 6'(i)] = wd[8*i +: 8];
            ref_stores = sat(ref_stores);
        end else if (!exp_e) begin
            last_load = ref_load(o, a);
            ref_loads = sat(ref_loads);
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " error"}, 32'(e), 32'(exp_e));
        chk({tag, " rw_overlap"}, 32'(both), 0);
        chk({tag, " load_data"}, load_data, last_load);
        chk({tag, " mem_word"}, mem[a[5:2]], ref_word(int'(a[5:2])));
        chk({tag, " load_count"}, 32'(load_count), ref_loads);
        chk({tag, " store_count"}, 32'(store_count), ref_stores);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vt[13];

    initial begin
        int          dones, lat;
        logic        e, both;
        logic [31:0] w, held;
        vt[0]  = '{0, 3'b000, 5,  0, 32'hFFFFFFAA, 0, 2};
        vt[1]  = '{0, 3'b101, 6,  0, 32'h00008899, 0, 2};
        vt[2]  = '{1, 3'b000, 9,  32'h000000EE, 32'h1122EE44, 0, 3};
        vt[3]  = '{0, 3'b011, 6,  0, 32'h00008899, 1, 1};
        vt[4]  = '{1, 3'b100, 8,  32'h12345678, 32'h1122EE44, 1, 1};
        vt[5]  = '{0, 3'b011, 8,  0, 32'h1122EE44, 0, 2};
        vt[6]  = '{0, 3'b001, 10, 0, 32'h00001122, 0, 2};
        vt[7]  = '{0, 3'b000, 6,  0, 32'hFFFFFF99, 0, 2};
        vt[8]  = '{0, 3'b100, 7,  0, 32'h00000088, 0, 2};
        vt[9]  = '{1, 3'b011, 12, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2};
        vt[10] = '{1, 3'b001, 14, 32'h1234CAFE, 32'hCAFEBEEF, 0, 3};
        vt[11] = '{0, 3'b010, 4,  0, 32'h00000088, 1, 1};
        vt[12] = '{0, 3'b001, 4,  0, 32'hFFFFAABB, 0, 2};

        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[1] = 32'h8899AABB;
        mem[2] = 32'h11223344;
        for (int i = 0; i < 64; i++) rb[i] = mem[i/4][8*(i%4) +: 8];
        ref_loads = 0; ref_stores = 0; last_load = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset ready", 32'(ready), 1);
        chk("reset done", 32'(done), 0);
        chk("reset stall", 32'(stall), 0);
        chk("reset memread", 32'(mem_read), 0);
        chk("reset memwrite", 32'(mem_write), 0);
        chk("reset memaddr", mem_addr, 0);
        chk("reset loaddata", load_data, 0);

        for (int i = 0; i < 13; i++) begin
            held = load_data;
            run(vt[i].st, vt[i].op, vt[i].addr, vt[i].wd, lat, e, both);
            chk($sformatf("vec%0d latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d error", i), 32'(e), 32'(vt[i].err));
            chk($sformatf("vec%0d rw_overlap", i), 32'(both), 0);
            if (vt[i].st) chk($sformatf("vec%0d mem", i), mem[vt[i].addr[5:2]], vt[i].exp);
            else chk($sformatf("vec%0d load", i), load_data, vt[i].exp);
            if (vt[i].st || vt[i].err) chk($sformatf("vec%0d load_held", i), load_data, held);
        end
        chk("table load_count", 32'(load_count), 7);
        chk("table store_count", 32'(store_count), 3);
        for (int i = 0; i < 64; i++) rb[i] = mem[i/4][8*(i%4) +: 8];

        // Reset while the RMW read of a halfword store is in flight.
        w = mem[0];
        valid = 1'b1; store = 1'b1; op = 3'b001; addr = 2; wdata = 32'h0000BEEF;
        @(posedge clk); #1;
        valid = 1'b0;
        chk("rst_mid in_rd", 32'(mem_read), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid ready", 32'(ready), 1);
        chk("rst_mid memread", 32'(mem_read), 0);
        chk("rst_mid memwrite", 32'(mem_write), 0);
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        chk("rst_mid no_done", dones, 0);
        chk("rst_mid mem_kept", mem[0], w);
        ref_loads = 0; ref_stores = 0; last_load = '0;

        // Valid held high: a new load is only taken once the unit is back in IDLE.
        valid = 1'b1; store = 1'b0; op = 3'b011; addr = 4;
        dones = 0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (done && ready) chk("b2b ready_in_resp", 32'(ready), 0);
        end
        valid = 1'b0;
        for (int k = 0; k < 3; k++) ref_loads = sat(ref_loads);
        last_load = ref_word(1);
        chk("b2b dones", dones, 3);
        chk("b2b ready", 32'(ready), 1);
        chk("b2b load_data", load_data, last_load);
        chk("b2b load_count", 32'(load_count), ref_loads);

        for (int n = 0; n < 250; n++) begin
            logic        rs;
            logic [2:0]  ro;
            logic [31:0] ra;
            rs = 1'($urandom_range(0, 1));
            ro = 3'($urandom_range(0, 7));
            ra = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) ra = ra & ~((ro == 3'b011) ? 32'd3 : 32'd1);
            txn($sformatf("rnd%0d", n), rs, ro, ra, $urandom);
        end
        chk("final load_count saturated", 32'(load_count), (1 << CB) - 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
